// File: rtl/xor_stream_pkg.sv
// xor_stream_pkg: keystream constants, FSM states and LFSR step shared by scrambler and descrambler.
package xor_stream_pkg;

    localparam int         DATA_W = 8;
    localparam logic [7:0] TAPS   = 8'hB8;

    typedef enum logic {UNSEEDED, RUN} state_t;

    function automatic logic [7:0] lfsr_next(input logic [7:0] lfsr, input logic [7:0] taps = TAPS);
        return (lfsr >> 1) ^ (lfsr[0] ? taps : 8'h00);
    endfunction

endpackage

// File: rtl/lfsr8_galois.sv
// lfsr8_galois: 8-bit Galois LFSR with load (priority) and step enable.
module lfsr8_galois #(
    parameter logic [7:0] TAPS = xor_stream_pkg::TAPS
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       step,
    output logic [7:0] q
);
    import xor_stream_pkg::*;

    always_ff @(posedge clk) begin
        if (rst)
            q <= '0;
        else if (load)
            q <= load_val;
        else if (step)
            q <= lfsr_next(q, TAPS);
    end

endmodule

// File: rtl/xor_stream_descrambler.sv
// xor_stream_descrambler: XORs accepted ciphertext bytes with a Galois LFSR keystream,
// presenting plaintext on a registered valid/ready output.
module xor_stream_descrambler #(
    parameter int         DATA_W = 8,
    parameter logic [7:0] TAPS   = xor_stream_pkg::TAPS,
    parameter int         CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              seed_load,
    input  logic [7:0]        seed_in,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              locked,
    output logic              seed_err,
    output logic [CNT_W-1:0]  byte_count
);
    import xor_stream_pkg::*;

    state_t     state, state_next;
    logic       seed_ok, accept;
    logic [7:0] lfsr;

    assign seed_ok = seed_load && (seed_in != 8'h00);

    always_ff @(posedge clk) begin
        if (rst)
            state <= UNSEEDED;
        else
            state <= state_next;
    end

    // seed_load blocks acceptance so load and step never coincide in the LFSR
    always_comb begin
        state_next = state;
        in_ready   = (state == RUN) && !seed_load && (!out_valid || out_ready);
        accept     = in_valid && in_ready;
        locked     = state == RUN;
        if (seed_load)
            state_next = seed_ok ? RUN : UNSEEDED;
    end

    lfsr8_galois #(.TAPS(TAPS)) u_lfsr (
        .clk      (clk),
        .rst      (rst),
        .load     (seed_ok),
        .load_val (seed_in),
        .step     (accept),
        .q        (lfsr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            byte_count <= '0;
            seed_err   <= 1'b0;
        end else begin
            seed_err <= seed_load && !seed_ok;
            if (accept) begin
                out_valid <= 1'b1;
                out_data  <= in_data ^ lfsr;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (seed_ok)
                byte_count <= '0;
            else if (accept)
                byte_count <= byte_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_xor_stream_descrambler.sv
// tb_xor_stream_descrambler: directed vectors with literal expectations plus a per-cycle
// behavioural model of the descrambler stream.
module tb_xor_stream_descrambler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        seed_load = 1'b0;
    logic [7:0]  seed_in = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_data = 8'h00;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  out_data;
    logic        locked;
    logic        seed_err;
    logic [15:0] byte_count;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    bit          m_locked = 1'b0;
    bit          m_ov = 1'b0;
    bit          m_err = 1'b0;
    logic [7:0]  m_ks = 8'h00;
    logic [7:0]  m_od = 8'h00;
    logic [15:0] m_cnt = 16'h0000;

    always #5 clk = ~clk;

    xor_stream_descrambler dut (
        .clk        (clk),
        .rst        (rst),
        .seed_load  (seed_load),
        .seed_in    (seed_in),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .locked     (locked),
        .seed_err   (seed_err),
        .byte_count (byte_count)
    );

    function automatic logic [7:0] ks_step(input logic [7:0] k);
        return k[0] ? ((k >> 1) ^ 8'hB8) : (k >> 1);
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: stream semantics applied per clock edge
    always @(posedge clk) begin
        bit acc;
        if (rst) begin
            m_locked = 0; m_ov = 0; m_err = 0; m_ks = 8'h00; m_od = 8'h00; m_cnt = 16'h0000;
        end else begin
            acc   = m_locked && !seed_load && (!m_ov || out_ready) && in_valid;
            m_err = seed_load && (seed_in == 8'h00);
            if (acc) begin
                m_od  = in_data ^ m_ks;
                m_ov  = 1;
                m_ks  = ks_step(m_ks);
                m_cnt = m_cnt + 16'd1;
            end else if (out_ready) begin
                m_ov = 0;
            end
            if (seed_load && seed_in != 8'h00) begin
                m_ks = seed_in; m_cnt = 16'h0000; m_locked = 1;
            end else if (seed_load) begin
                m_locked = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            cmp("m_in_ready", in_ready, m_locked && !seed_load && (!m_ov || out_ready));
            cmp("m_out_valid", out_valid, m_ov);
            cmp("m_locked", locked, m_locked);
            cmp("m_seed_err", seed_err, m_err);
            cmp("m_byte_count", byte_count, m_cnt);
            if (m_ov) cmp("m_out_data", out_data, m_od);
        end
    end

    task automatic drive(input logic sl, input logic [7:0] si, input logic iv, input logic [7:0] id, input logic ordy);
        seed_load = sl; seed_in = si; in_valid = iv; in_data = id; out_ready = ordy;
        @(posedge clk); #1;
    endtask

    logic [7:0] zero_ks [5] = '{8'h01, 8'hB8, 8'h5C, 8'h2E, 8'h17};

    initial begin
        repeat (2) drive(0, 8'h00, 0, 8'h00, 0);
        rst = 0;
        chk_en = 1;

        // No seed: nothing is accepted
        drive(0, 8'h00, 1, 8'h55, 1);
        cmp("unseeded_in_ready", in_ready, 0);
        cmp("unseeded_out_valid", out_valid, 0);
        cmp("unseeded_locked", locked, 0);
        cmp("unseeded_count", byte_count, 0);

        // Seed 0x01, stream three bytes
        drive(1, 8'h01, 0, 8'h00, 1);
        cmp("seeded_locked", locked, 1);
        drive(0, 8'h00, 1, 8'h41, 1);
        cmp("stream_b0", out_data, 8'h40);
        drive(0, 8'h00, 1, 8'h42, 1);
        cmp("stream_b1", out_data, 8'hFA);
        drive(0, 8'h00, 1, 8'h43, 1);
        cmp("stream_b2", out_data, 8'h1F);
        cmp("stream_count", byte_count, 3);
        drive(0, 8'h00, 0, 8'h00, 1);
        cmp("stream_drained", out_valid, 0);

        // Backpressure holds data and keystream
        drive(1, 8'h01, 0, 8'h00, 1);
        drive(0, 8'h00, 1, 8'h41, 0);
        repeat (3) begin
            drive(0, 8'h00, 1, 8'h42, 0);
            cmp("bp_in_ready", in_ready, 0);
            cmp("bp_hold_data", out_data, 8'h40);
            cmp("bp_count", byte_count, 1);
        end
        drive(0, 8'h00, 1, 8'h42, 1);
        cmp("bp_release", out_data, 8'hFA);
        drive(0, 8'h00, 0, 8'h00, 1);

        // Raw keystream, then reseed beats a same-cycle accept
        drive(1, 8'h01, 0, 8'h00, 1);
        for (int i = 0; i < 5; i++) begin
            drive(0, 8'h00, 1, 8'h00, 1);
            cmp("keystream", out_data, zero_ks[i]);
        end
        drive(1, 8'h01, 1, 8'h00, 1);
        cmp("reseed_no_accept", out_valid, 0);
        cmp("reseed_count", byte_count, 0);
        drive(0, 8'h00, 1, 8'h00, 1);
        cmp("reseed_b0", out_data, 8'h01);
        cmp("reseed_count1", byte_count, 1);
        drive(0, 8'h00, 0, 8'h00, 1);

        // Zero seed in RUN with a pending byte
        drive(0, 8'h00, 1, 8'h41, 0);
        cmp("pend_data", out_data, 8'hF9);
        drive(1, 8'h00, 0, 8'h00, 0);
        cmp("zseed_err", seed_err, 1);
        cmp("zseed_locked", locked, 0);
        cmp("zseed_pending", out_valid, 1);
        drive(0, 8'h00, 1, 8'h33, 0);
        cmp("zseed_err_once", seed_err, 0);
        cmp("zseed_in_ready", in_ready, 0);
        cmp("zseed_hold", out_data, 8'hF9);
        drive(0, 8'h00, 1, 8'h33, 1);
        cmp("zseed_drained", out_valid, 0);

        // Counter wrap and keystream period
        drive(1, 8'h01, 0, 8'h00, 1);
        for (int i = 1; i <= 65535; i++) begin
            drive(0, 8'h00, 1, 8'h00, 1);
            if (i == 256) cmp("period_255", out_data, 8'h01);
        end
        cmp("count_max", byte_count, 16'hFFFF);
        drive(0, 8'h00, 1, 8'h00, 1);
        cmp("count_wrap", byte_count, 0);
        cmp("wrap_data", out_data, 8'h01);

        // Reset mid-stream drops the pending byte
        drive(0, 8'h00, 0, 8'h00, 0);
        drive(0, 8'h00, 1, 8'h41, 0);
        rst = 1;
        drive(0, 8'h00, 0, 8'h00, 0);
        rst = 0;
        cmp("rst_out_valid", out_valid, 0);
        cmp("rst_locked", locked, 0);
        drive(0, 8'h00, 1, 8'h41, 1);
        cmp("rst_needs_seed", in_ready, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/xor_stream_descrambler.md
Name: xor_stream_descrambler

Overview:
- Receive-side counterpart of the team's XOR byte scrambler. Takes ciphertext bytes on a valid/ready stream and XORs each one with an 8-bit Galois LFSR keystream to recover plaintext.
- The LFSR is seeded identically to the transmitter and advances once per accepted byte.
- Output is a registered valid/ready stream.
- Sits between the pad-side byte capture and the user logic of the Tiny Tapeout tile.

Parameters:
- DATA_W, 8, byte width; fixed at 8, other values unsupported.
- TAPS, 8'hB8, Galois feedback mask (x^8+x^6+x^5+x^4+1, maximal, period 255).
- CNT_W, 16, width of the accepted-byte counter.

Ports:
- clk  in  1  clock, all logic rising-edge.
- rst  in  1  reset, synchronous, active-high.
- seed_load  in  1  single-cycle strobe to load seed_in into the LFSR.
- seed_in  in  8  keystream seed; 8'h00 is illegal.
- in_valid  in  1  ciphertext byte valid.
- in_ready  out  1  block accepts in_data this cycle.
- in_data  in  8  ciphertext byte.
- out_valid  out  1  plaintext byte valid.
- out_ready  in  1  downstream accepts out_data.
- out_data  out  8  plaintext byte.
- locked  out  1  high while state==RUN.
- seed_err  out  1  one-cycle pulse when seed_load is presented with seed_in==0.
- byte_count  out  CNT_W  number of bytes accepted since the last valid seed.

Behaviour:
- Interface: one clock domain on clk; reset rst is synchronous and active-high.
- Reset values:
  - state=UNSEEDED, lfsr=8'h00
  - out_valid=0, out_data=0, byte_count=0, seed_err=0, locked=0
- FSM states:
  - UNSEEDED: in_ready=0.
  - RUN: normal operation.
- FSM transitions:
  - seed_load with seed_in!=0, from any state: lfsr<=seed_in, byte_count<=0, state<=RUN.
  - seed_load with seed_in==0, from any state: seed_err pulses next cycle, state<=UNSEEDED, lfsr unchanged.
- in_ready is combinational: in_ready = (state==RUN) && !seed_load && (!out_valid || out_ready). seed_load therefore always wins over an accept in the same cycle.
- Accept (in_valid && in_ready):
  - out_data <= in_data ^ lfsr
  - out_valid <= 1
  - lfsr <= (lfsr>>1) ^ (lfsr[0] ? TAPS : 0)
  - byte_count <= byte_count+1, wrapping 0xFFFF -> 0x0000
- Latency and throughput: 1 cycle from accept to out_valid; full throughput of 1 byte/cycle when out_ready is held high.
- Output handshake:
  - If out_valid && out_ready and there is no accept that cycle, out_valid <= 0.
  - While out_valid && !out_ready, out_data is held stable.
- Reseed with a byte pending: the pending out_data is kept, since it was already decoded with the old keystream. Only subsequent bytes use the new seed.
- A zero seed while in RUN drops to UNSEEDED. A pending output byte still drains normally.
- LFSR state 0 is unreachable in RUN.
- The keystream repeats every 255 accepted bytes; this is not flagged.
- rst asserted mid-stream discards the pending byte (out_valid=0 next cycle) and requires a reseed.

Decomposition:
- Package xor_stream_pkg holds:
  - TAPS constant
  - state enum {UNSEEDED, RUN}
  - pure function lfsr_next(lfsr)
- The package is shared with the transmit-side scrambler so both ends use identical keystreams.
- Sub-module lfsr8_galois (ports: clk, rst, load, load_val, step, q), also instantiated by the scrambler.

Test Plan:
- Reset then in_valid=1 with no seed -> in_ready=0, out_valid=0, locked=0, byte_count=0.
- Seed 0x01, stream 0x41,0x42,0x43 with out_ready=1 -> out_data 0x40,0xFA,0x1F on consecutive cycles, byte_count=3, locked=1.
- Seed 0x01, out_ready held 0 for 3 cycles after the first accept -> in_ready=0, out_data held at 0x40, no LFSR advance; on release the next byte 0x42 decodes to 0xFA.
- Seed 0x01, accept 5 bytes of 0x00 -> outputs 0x01,0xB8,0x5C,0x2E,0x17; then seed_load 0x01 with in_valid=1 in the same cycle -> no accept that cycle, next 0x00 decodes to 0x01, byte_count back to 1.
- seed_load with seed_in=0x00 while in RUN -> seed_err=1 for exactly one cycle, locked=0, in_ready=0, pending byte still delivered.
- Force byte_count to 0xFFFF via 65535 accepts (or a shortened CNT_W=4 build: 15 accepts), then one more accept -> byte_count wraps to 0; a 255-byte run of 0x00 followed by one more byte reproduces keystream byte 0x01.
